// File: rtl/seg7_scan_display.sv
// seg7_scan_display: sequential double-dabble BCD conversion feeding a multiplexed
// common-cathode scan with leading-zero blanking, inter-digit blank gap and overflow dashes.
module seg7_scan_display #(
  parameter int DIGITS = 4,
  parameter int IN_W = 14,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC = 8,
  parameter bit SEG_ACTIVE_LOW = 0,
  parameter bit AN_ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [IN_W-1:0]   value_i,
  output logic              busy_o,
  output logic              overflow_o,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2;
  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(IN_W + 1);
  localparam int PW = $clog2(REFRESH_DIV + 1);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [63:0] MAX_V = 64'(10 ** DIGITS) - 64'd1;

  logic [1:0]        state_q, state_d;
  logic [IN_W-1:0]   bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d, adj, disp_q, disp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_cap_q, ovf_cap_d, ovf_q, ovf_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              wrap, blank, lz;
  logic [3:0]        nib;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: dec = 7'b1111110;
      4'd1: dec = 7'b0110000;
      4'd2: dec = 7'b1101101;
      4'd3: dec = 7'b1111001;
      4'd4: dec = 7'b0110011;
      4'd5: dec = 7'b1011011;
      4'd6: dec = 7'b1011111;
      4'd7: dec = 7'b1110010;
      4'd8: dec = 7'b1111111;
      4'd9: dec = 7'b1111011;
      default: dec = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      adj[i*4 +: 4] = bcd_q[i*4 +: 4] >= 4'd5 ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
  end

  always_comb begin
    state_d = state_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    ovf_cap_d = ovf_cap_q;
    disp_d = disp_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && load_i) begin
      state_d = SHIFT;
      bin_d = value_i;
      bcd_d = '0;
      cnt_d = CW'(IN_W);
      ovf_cap_d = 64'(value_i) > MAX_V;
    end else if (state_q == SHIFT) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == CW'(1) ? COMMIT : SHIFT;
    end else if (state_q == COMMIT) begin
      disp_d = bcd_q;
      ovf_d = ovf_cap_q;
      state_d = IDLE;
    end
  end

  // Digits above the highest non-zero one are blank; digit 0 always shows.
  always_comb begin
    wrap = pre_q == PW'(REFRESH_DIV - 1);
    pre_d = wrap ? '0 : pre_q + 1'b1;
    idx_d = wrap ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    nib = disp_q[idx_q*4 +: 4];
    lz = idx_q != '0 && (disp_q >> {idx_q, 2'b00}) == '0;
    blank = pre_q < PW'(BLANK_CYC);
    seg_d = blank ? 7'b0 : ovf_q ? 7'b0000001 : lz ? 7'b0 : dec(nib);
    an_d = blank ? '0 : DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_cap_q <= 1'b0;
      disp_q <= '0;
      ovf_q <= 1'b0;
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= '0;
      an_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      ovf_cap_q <= ovf_cap_d;
      disp_q <= disp_d;
      ovf_q <= ovf_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q <= an_d;
    end

  assign busy_o = state_q != IDLE;
  assign overflow_o = ovf_q;
  assign seg_o = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign an_o = an_q ^ {DIGITS{AN_ACTIVE_LOW}};
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: checks normal and inverted-polarity instances against an
// arithmetic model of the displayed number, conversion latency and scan position.
module tb_seg7_scan_display;
  localparam int D = 4, W = 14, RD = 4, BC = 1;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [W-1:0] value = '0;
  logic busy_a, ovf_a, busy_b, ovf_b;
  logic [6:0] seg_a, seg_b;
  logic [D-1:0] an_a, an_b;
  int passed = 0, total = 0;
  int cyc = 0, busy_left = 0, m_val = 0, pend = 0;
  bit m_ovf = 1'b0;
  logic [6:0] lut [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011};

  always #5 clk = ~clk;

  seg7_scan_display #(.DIGITS(D), .IN_W(W), .REFRESH_DIV(RD), .BLANK_CYC(BC),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .load_i(load), .value_i(value),
    .busy_o(busy_a), .overflow_o(ovf_a), .seg_o(seg_a), .an_o(an_a));

  seg7_scan_display #(.DIGITS(D), .IN_W(W), .REFRESH_DIV(RD), .BLANK_CYC(BC),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst(rst), .load_i(load), .value_i(value),
    .busy_o(busy_b), .overflow_o(ovf_b), .seg_o(seg_b), .an_o(an_b));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
  endtask

  function automatic logic [6:0] exp_digit(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    if (m_ovf) return 7'b0000001;
    if (i > 0 && m_val < p) return 7'b0;
    return lut[(m_val / p) % 10];
  endfunction

  // Registered outputs after this edge reflect the model state just before it.
  task automatic step();
    logic [6:0] es, es_n;
    logic [D-1:0] ea, ea_n;
    int pre, idx;
    pre = cyc % RD;
    idx = (cyc / RD) % D;
    es = '0;
    ea = '0;
    if (!rst && pre >= BC) begin
      es = exp_digit(idx);
      ea[idx] = 1'b1;
    end
    es_n = ~es;
    ea_n = ~ea;
    if (rst) begin
      cyc = 0;
      busy_left = 0;
      m_val = 0;
      m_ovf = 1'b0;
    end else begin
      cyc++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          m_val = pend;
          m_ovf = pend > 9999;
        end
      end else if (load) begin
        busy_left = W + 1;
        pend = int'(value);
      end
    end
    @(posedge clk);
    #1;
    check("seg", seg_a, es);
    check("an", an_a, ea);
    check("busy", busy_a, busy_left > 0);
    check("overflow", ovf_a, m_ovf);
    check("seg_inv", seg_b, es_n);
    check("an_inv", an_b, ea_n);
    check("busy_inv", busy_b, busy_left > 0);
    check("overflow_inv", ovf_b, m_ovf);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic ld(input int v);
    value = W'(v);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    run(32);
    ld(1234);
    run(40);
    ld(9999);
    run(40);
    ld(10000);
    run(40);
    ld(37);
    run(3);
    ld(500);
    run(40);
    ld(4321);
    run(7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(40);
    ld(0);
    run(20);
    ld(7);
    run(14);
    ld(8765);
    run(24);
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 5));
      value = r == 0 ? W'(9999) : r == 1 ? W'(10000) : W'($urandom_range(0, 16383));
      load = $urandom_range(0, 3) == 0;
      step();
    end
    load = 1'b0;
    run(40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
